wb_write_scheduler: RTL and testbench

//  Schedules the register-bank write port among six write-back sources that feed
//  mux_WD_Registers (data_1..data_6). Drives the mux selector, reg_write and

---
 rtl/wb_write_scheduler.sv | 128 ++++++++++++
 tb/tb_wb_write_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_scheduler.sv
// Register-bank write-port scheduler: one-time stack-pointer init write, then
// round-robin or fixed-priority arbitration among six write-back sources.
module wb_write_scheduler #(
  parameter logic [4:0] SP_REG    = 5'd29,
  parameter bit         RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  req,
  input  logic [29:0] req_addr,
  output logic [5:0]  grant,
  output logic [2:0]  wd_sel,
  output logic [4:0]  write_reg,
  output logic        reg_write,
  output logic        init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  state_e      state_q,     state_d;
  logic [2:0]  rr_ptr_q,    rr_ptr_d;
  logic [5:0]  grant_q,     grant_d;
  logic [2:0]  wd_sel_q,    wd_sel_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        init_done_q, init_done_d;

  logic [5:0]  eligible;
  logic [5:0]  upper_mask;
  logic [5:0]  eligible_hi;
  logic [2:0]  winner;
  logic [4:0]  winner_addr;

  function automatic logic [2:0] lowest_idx(input logic [5:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // The source granted this cycle is masked so its one-cycle req drop latency
  // never produces a back-to-back duplicate grant.
  assign eligible = req & ~grant_q;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      upper_mask[i] = (3'(i) > rr_ptr_q);
    end
  end

  assign eligible_hi = eligible & upper_mask;

  always_comb begin
    if (RR_ENABLE && (eligible_hi != 6'd0)) winner = lowest_idx(eligible_hi);
    else                                    winner = lowest_idx(eligible);
  end

  always_comb begin
    winner_addr = 5'd0;
    for (int i = 0; i < 6; i++) begin
      if (winner == 3'(i)) winner_addr = req_addr[5*i +: 5];
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = 6'd0;
    wd_sel_d    = wd_sel_q;
    write_reg_d = write_reg_q;
    reg_write_d = 1'b0;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        reg_write_d = 1'b1;
        wd_sel_d    = 3'd0;
        write_reg_d = SP_REG;
        init_done_d = 1'b1;
        state_d     = ST_ARB;
      end
      ST_ARB: begin
        if (eligible != 6'd0) begin
          grant_d     = 6'b000001 << winner;
          wd_sel_d    = winner + 3'd1;
          write_reg_d = winner_addr;
          // $zero is never written, but the handshake still completes.
          reg_write_d = (winner_addr != 5'd0);
          rr_ptr_d    = winner;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      rr_ptr_q    <= 3'd5;
      grant_q     <= 6'd0;
      wd_sel_q    <= 3'd0;
      write_reg_q <= 5'd0;
      reg_write_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      wd_sel_q    <= wd_sel_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      init_done_q <= init_done_d;
    end
  end

  assign grant     = grant_q;
  assign wd_sel    = wd_sel_q;
  assign write_reg = write_reg_q;
  assign reg_write = reg_write_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Scoreboard bench for wb_write_scheduler: a round-robin and a fixed-priority
// instance share stimulus; a behavioural model predicts both each cycle.
module tb_wb_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  req;
  logic [29:0] req_addr;

  logic [5:0] g_rr, g_fp;
  logic [2:0] sel_rr, sel_fp;
  logic [4:0] wr_rr, wr_fp;
  logic       rw_rr, rw_fp, id_rr, id_fp;

  always #5 clk = ~clk;

  wb_write_scheduler #(.SP_REG(5'd29), .RR_ENABLE(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .grant(g_rr), .wd_sel(sel_rr), .write_reg(wr_rr),
    .reg_write(rw_rr), .init_done(id_rr)
  );

  wb_write_scheduler #(.SP_REG(5'd29), .RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .grant(g_fp), .wd_sel(sel_fp), .write_reg(wr_fp),
    .reg_write(rw_fp), .init_done(id_fp)
  );

  typedef struct packed {
    logic       pend;
    logic [2:0] rr;
    logic [5:0] grant;
    logic [2:0] sel;
    logic [4:0] wreg;
    logic       rw;
    logic       init;
  } mstate_t;

  typedef struct packed {
    logic [15:0] rr;
    logic [15:0] fp;
  } exp_t;

  mstate_t     m_rr, m_fp;
  exp_t        sb_q[$];
  logic [5:0]  cur_req;
  logic [29:0] cur_addr;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack(input mstate_t s);
    return {s.grant, s.sel, s.wreg, s.rw, s.init};
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input bit rr_en, input logic rst,
                                     input logic [5:0] r, input logic [29:0] a);
    mstate_t    n;
    logic [5:0] elig;
    int         w;
    n = s;
    if (rst) begin
      n = '0;
      n.pend = 1'b1;
      n.rr   = 3'd5;
    end else if (s.pend) begin
      n.pend  = 1'b0;
      n.grant = 6'd0;
      n.sel   = 3'd0;
      n.wreg  = 5'd29;
      n.rw    = 1'b1;
      n.init  = 1'b1;
    end else begin
      elig    = r & ~s.grant;
      n.grant = 6'd0;
      n.rw    = 1'b0;
      if (elig != 6'd0) begin
        w = -1;
        for (int k = 0; k < 6; k++) begin
          int idx;
          idx = rr_en ? (int'(s.rr) + 1 + k) % 6 : k;
          if (w < 0 && elig[idx]) w = idx;
        end
        n.grant = 6'(1 << w);
        n.sel   = 3'(w + 1);
        n.wreg  = a[5*w +: 5];
        n.rw    = (n.wreg != 5'd0);
        n.rr    = 3'(w);
      end
    end
    return n;
  endfunction

  // One clock: requesters drop req when their grant ends (if in drop_mask),
  // new requests are raised, the model predicts, the DUT result is compared.
  task automatic tick(input logic rst_v, input logic [5:0] set_req, input logic [5:0] drop_mask);
    exp_t e;
    @(negedge clk);
    cur_req  = (cur_req & ~(m_rr.grant & drop_mask)) | set_req;
    reset    = rst_v;
    req      = cur_req;
    req_addr = cur_addr;
    m_rr = m_step(m_rr, 1'b1, rst_v, cur_req, cur_addr);
    m_fp = m_step(m_fp, 1'b0, rst_v, cur_req, cur_addr);
    sb_q.push_back('{rr: pack(m_rr), fp: pack(m_fp)});
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check($sformatf("sb_rr@%0d", cyc), {g_rr, sel_rr, wr_rr, rw_rr, id_rr}, e.rr);
    check($sformatf("sb_fp@%0d", cyc), {g_fp, sel_fp, wr_fp, rw_fp, id_fp}, e.fp);
  endtask

  task automatic clear_reqs(input int idle);
    cur_req = 6'd0;
    for (int i = 0; i < idle; i++) tick(1'b0, 6'd0, 6'd0);
  endtask

  initial begin
    cur_req  = 6'd0;
    cur_addr = 30'd0;
    reset    = 1'b1;
    req      = 6'd0;
    req_addr = 30'd0;
    m_rr     = '0;
    m_fp     = '0;

    // Reset, then the one-time SP init write.
    for (int i = 0; i < 3; i++) tick(1'b1, 6'd0, 6'd0);
    check("reset_grant", 16'(g_rr), 16'd0);
    check("reset_init_done", 16'(id_rr), 16'd0);
    tick(1'b0, 6'd0, 6'd0);
    check("init_write_reg", 16'(wr_rr), 16'd29);
    check("init_ctrl", {13'd0, rw_rr, id_rr, (sel_rr == 3'd0)}, 16'b111);
    tick(1'b0, 6'd0, 6'd0);
    check("post_init_idle", {9'd0, g_rr, rw_rr}, 16'd0);

    // Request held across INIT is served right after it.
    tick(1'b1, 6'd0, 6'd0);
    tick(1'b1, 6'd0, 6'd0);
    cur_addr[14:10] = 5'd8;
    tick(1'b0, 6'b000100, 6'h3f);
    check("init_ignores_req", 16'(g_rr), 16'd0);
    check("init_ignores_req_wr", 16'(wr_rr), 16'd29);
    tick(1'b0, 6'd0, 6'h3f);
    check("t2_grant_rr", {g_rr, sel_rr, wr_rr, rw_rr, 1'b1}, {6'b000100, 3'd3, 5'd8, 1'b1, 1'b1});
    check("t2_grant_fp", {g_fp, sel_fp, wr_fp, rw_fp, 1'b1}, {6'b000100, 3'd3, 5'd8, 1'b1, 1'b1});
    tick(1'b0, 6'd0, 6'h3f);

    // All six held, then each drops once served; covers the 5->0 wrap.
    for (int i = 0; i < 6; i++) cur_addr[5*i +: 5] = 5'(10 + i);
    tick(1'b0, 6'h3f, 6'd0);
    for (int i = 0; i < 13; i++) tick(1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 6'd0, 6'h3f);
    clear_reqs(2);

    // Fixed priority with mask: 1, 3, 1.
    tick(1'b0, 6'b101010, 6'd0);
    check("fp_first_1", 16'(g_fp), 16'b000010);
    tick(1'b0, 6'd0, 6'd0);
    check("fp_mask_3", 16'(g_fp), 16'b001000);
    tick(1'b0, 6'd0, 6'd0);
    check("fp_back_1", 16'(g_fp), 16'b000010);
    clear_reqs(2);

    // Write to $zero: grant issued, no write enable.
    cur_addr[24:20] = 5'd0;
    tick(1'b0, 6'b010000, 6'h3f);
    check("zero_rr", {g_rr, sel_rr, wr_rr, rw_rr, 1'b0}, {6'b010000, 3'd5, 5'd0, 1'b0, 1'b0});
    check("zero_fp", {g_fp, sel_fp, wr_fp, rw_fp, 1'b0}, {6'b010000, 3'd5, 5'd0, 1'b0, 1'b0});
    clear_reqs(2);

    // Reset during a grant cycle squashes it; INIT repeats, then grant[0].
    cur_addr[4:0] = 5'd17;
    tick(1'b0, 6'b000001, 6'd0);
    check("pre_reset_grant", 16'(g_rr), 16'b000001);
    tick(1'b1, 6'd0, 6'd0);
    check("squash_grant", {9'd0, g_rr, rw_rr}, 16'd0);
    tick(1'b0, 6'd0, 6'd0);
    check("reinit_write", {10'd0, wr_rr, rw_rr}, {10'd0, 5'd29, 1'b1});
    tick(1'b0, 6'd0, 6'd0);
    check("regrant_0", {g_rr, sel_rr, wr_rr, 2'b00}, {6'b000001, 3'd1, 5'd17, 2'b00});
    clear_reqs(2);

    // Random traffic with handshake-respecting requesters and rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] new_req;
      logic       rst_v;
      for (int s = 0; s < 6; s++) begin
        if (!cur_req[s]) cur_addr[5*s +: 5] = 5'($urandom_range(0, 31));
      end
      new_req = 6'($urandom) & 6'($urandom);
      rst_v   = ($urandom_range(0, 59) == 0);
      tick(rst_v, new_req, 6'h3f);
    end
    clear_reqs(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
